// File: rtl/alu_74181_seq.sv
// alu_74181_seq: multi-cycle WIDTH-bit ALU built from a chain of 4-bit 74181
// slices, SLICES_PER_CYCLE slices evaluated per beat.
// Handshake: an operation is accepted when start=1 and ena=1 in IDLE.
// busy is high while the FSM is in RUN. done pulses for one enabled cycle,
// and from that cycle f/cn_out/equal are valid.
// ena=0 freezes every register, including a pending done.
module alu_74181_seq #(
    parameter int WIDTH            = 16,
    parameter int SLICES_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cn,
    output logic [WIDTH-1:0] f,
    output logic             cn_out,
    output logic             equal,
    output logic             busy,
    output logic             done
);

    localparam int BW = 4 * SLICES_PER_CYCLE;          // bits per beat
    localparam int N  = WIDTH / BW;                    // beats per operation
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state, state_nx;
    logic              accept, last_beat;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [3:0]        s_q;
    logic              m_q;
    logic              cn_q;        // active-low carry into the current beat
    logic              eq_acc;
    logic [BW-1:0]     a_beat, b_beat, f_beat;
    logic              carry_top;   // active-high carry out of the beat

    // One 74181 slice with active-high data. The function table reduces to
    // F = X + Y + cin (arithmetic) or F = ~(X ^ Y) (logic). Returns
    // {carry_out_active_high, f}. In logic mode the carry is forced inactive.
    function automatic logic [4:0] slice_eval(input logic [3:0] sa,
                                              input logic [3:0] sb,
                                              input logic [3:0] sel,
                                              input logic       mode,
                                              input logic       cin);
        logic [3:0] x, y;
        logic [4:0] sum;
        x   = sa | (sb & {4{sel[0]}}) | (~sb & {4{sel[1]}});
        y   = (sa & ~sb & {4{sel[2]}}) | (sa & sb & {4{sel[3]}});
        sum = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
        if (mode)
            slice_eval = {1'b0, ~(x ^ y)};
        else
            slice_eval = sum;
    endfunction

    // Next-state logic: accept a start in IDLE, leave RUN on the last beat.
    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        last_beat = 1'b0;
        case (state)
            IDLE: begin
                if (ena && start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (ena && (cnt == LAST)) begin
                    last_beat = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    assign busy = (state == RUN);

    // Beat datapath: ripple the carry through this beat's slices, LSB first.
    always_comb begin
        logic       c;
        logic [4:0] r;
        a_beat = a_q[int'(cnt) * BW +: BW];
        b_beat = b_q[int'(cnt) * BW +: BW];
        f_beat = '0;
        c      = m_q ? 1'b0 : ~cn_q;
        r      = '0;
        for (int i = 0; i < SLICES_PER_CYCLE; i++) begin
            r               = slice_eval(a_beat[i*4 +: 4], b_beat[i*4 +: 4], s_q, m_q, c);
            f_beat[i*4 +: 4] = r[3:0];
            c               = r[4];
        end
        carry_top = c;
    end

    // Operand latch, beat accumulation and result/done registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            m_q    <= 1'b0;
            cn_q   <= 1'b1;
            cnt    <= '0;
            eq_acc <= 1'b1;
            f      <= '0;
            cn_out <= 1'b1;
            equal  <= 1'b0;
            done   <= 1'b0;
        end else if (ena) begin
            done <= 1'b0;
            if (accept) begin
                a_q    <= a;
                b_q    <= b;
                s_q    <= s;
                m_q    <= m;
                cn_q   <= cn;
                cnt    <= '0;
                eq_acc <= 1'b1;
                f      <= '0;
            end else if (state == RUN) begin
                f[int'(cnt) * BW +: BW] <= f_beat;
                eq_acc                  <= eq_acc & (&f_beat);
                cn_q                    <= ~carry_top;
                cnt                     <= cnt + CW'(1);
                if (last_beat) begin
                    cnt    <= '0;
                    cn_out <= m_q | ~carry_top;
                    equal  <= eq_acc & (&f_beat);
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/alu_74181_seq.md
# alu_74181_seq

Parametrised, multi-cycle successor to the single-nibble 74181 ALU. It processes a WIDTH-bit operand pair as a chain of 4-bit 74181 slices and evaluates SLICES_PER_CYCLE slices per clock. Carry and equality are registered between beats, and completion is signalled with a start/busy/done handshake. It sits between the SPI config/status register bank and the 7-segment path. The config registers drive its operands and `start`, and the status registers capture `f`, `cn_out`, `equal` and `done`.

## Interface
- `WIDTH`, default 16: operand width. Must be a multiple of 4 and at least 4.
- `SLICES_PER_CYCLE`, default 1: 4-bit slices evaluated per beat. (WIDTH/4) must be divisible by it.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `ena`  in  1: clock enable. When low, all state holds and `start` is ignored.
- `start`  in  1: one-cycle request. Sampled only in IDLE with `ena`=1.
- `a`, `b`  in  WIDTH: operands. Latched on an accepted `start`.
- `s`  in  4: 74181 function select. Latched on `start`.
- `m`  in  1: mode. 1 = logic, 0 = arithmetic. Latched on `start`.
- `cn`  in  1: carry in, active-low (1 = no carry). Latched on `start`.
- `f`  out  WIDTH: result. Registered and held until the next accepted `start`.
- `cn_out`  out  1: carry out of the top slice, active-low.
- `equal`  out  1: AND of all `f` bits (the 74181 A=B convention).
- `busy`  out  1: high while an operation is in progress.
- `done`  out  1: one-cycle pulse when `f`, `cn_out` and `equal` become valid.

## Operation
- Slice function: standard 74181 with active-high data and active-low carry in and out.
  - Examples: S=1001,M=0 gives F=A+B+!cn. S=0110,M=0 gives F=A−B−cn. S=0110,M=1 gives A^B. S=1011,M=1 gives A&B. S=1110,M=1 gives A|B. S=0000,M=1 gives ~A. S=0011,M=1 gives 0. S=1100,M=1 gives all ones.
- Beat count: N = WIDTH/(4*SLICES_PER_CYCLE). The beat counter width is ceil(log2(N)), minimum 1.
- FSM has two states: IDLE and RUN.
- IDLE → RUN on `start`&`ena`. On that edge:
  - latch `a`, `b`, `s`, `m`, `cn`;
  - carry register ← `cn`; beat counter ← 0; equality accumulator ← 1;
  - clear `f` to 0.
- RUN, on each `ena` edge (beat k):
  - Evaluate slices k*SPC … k*SPC+SPC−1, least significant first.
  - Chain carry combinationally within the beat; the carry register receives the top slice's carry.
  - Write f[k*4*SPC +: 4*SPC]. AND the accumulator with the AND of those bits.
- RUN → IDLE on the beat where k = N−1. On that edge:
  - `cn_out` ← final carry; `equal` ← final accumulator; `done` ← 1; `busy` ← 0.
- M=1: the carry chain is forced inactive and `cn_out` reports 1. This intentionally deviates from the real chip.
- `start` in RUN is ignored: no queuing, no error flag.
- `start` in the cycle where `done`=1 (state IDLE) is accepted, giving back-to-back operation.
- `ena`=0: FSM, counter, carry, accumulator and outputs all freeze. `done`, if high, stays high until the next `ena` edge.
- `rst` asserted, including mid-operation, forces IDLE with the reset values below. The aborted operation produces no `done`.

## Timing
- Reset values: f=0, cn_out=1, equal=0, busy=0, done=0, state IDLE, counter=0.
- If `start` is accepted at edge 0:
  - `busy`=1 after edge 0;
  - `busy`=0 and `done`=1 after edge N;
  - `done` returns to 0 after edge N+1 unless a new operation completes.
- Latency is N enabled cycles; each `ena`=0 cycle adds one.
- Defaults: N=4. With SPC=4: N=1, `done` one cycle after `start`.
- `f`, `cn_out` and `equal` are valid from `done` onward and stable until the next accepted `start`.
- Partial `f` during RUN is not guaranteed.
- Inputs are synchronous to `clk`; synchronisation is the caller's responsibility.
- `rst` deassertion is assumed synchronous to `clk` externally.

## Test plan
- Add, WIDTH=16, SPC=1: A=0x1234, B=0x0FCD, S=1001, M=0, cn=1 → `done` 4 cycles after `start`, f=0x2201, cn_out=1, equal=0, busy high for exactly 4 cycles.
- Carry wrap: A=0xFFFF, B=0x0001, add, cn=1 → f=0x0000, cn_out=0. Same with SPC=4 → identical result, `done` 1 cycle after `start`.
- Compare: A=B=0x5A5A, S=0110, M=0, cn=1 → f=0xFFFF, equal=1, cn_out=1. Repeat with cn=0 → f=0x0000, equal=0, cn_out=0.
- Logic: A=0xF0F0, B=0xFF00, S=0110, M=1 → f=0x0FF0, cn_out=1. S=1011 → 0xF000. S=1110 → 0xFFF0.
- Handshake:
  - `start` pulsed again during RUN → ignored, single `done`, result from the first operands.
  - `ena` low for 2 cycles mid-RUN → `done` at 6 cycles with the correct result.
  - New `start` in the `done` cycle → second result 4 cycles later.
- Reset: assert `rst` at beat 2 of an add → busy=0, f=0, cn_out=1, no `done`. A subsequent add of 0x0001+0x0001 → f=0x0002 after 4 cycles.
